// File: rtl/uart_echo_ctrl_pkg.sv
// Shared encodings for the UART echo controller: transform modes and ASCII case bounds.
package uart_echo_ctrl_pkg;

   typedef enum logic [1:0] {
      MODE_PASS    = 2'b00,
      MODE_UPPER   = 2'b01,
      MODE_INV     = 2'b10,
      MODE_DISCARD = 2'b11
   } mode_e;

   localparam logic [7:0] ASCII_LC_LO    = 8'h61;
   localparam logic [7:0] ASCII_LC_HI    = 8'h7A;
   localparam logic [7:0] ASCII_CASE_OFS = 8'h20;

endpackage

// File: rtl/echo_fifo.sv
// Small first-word-fall-through buffer between the rx pop side and the tx push side.
module echo_fifo #(
   parameter int unsigned DBIT   = 8,
   parameter int unsigned BUF_AW = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_push,
   input  logic              i_pop,
   input  logic [DBIT-1:0]   i_wdata,
   output logic [DBIT-1:0]   o_rdata,
   output logic              o_full,
   output logic              o_empty,
   output logic [BUF_AW:0]   o_level
);

   localparam int unsigned     DEPTH    = 2 ** BUF_AW;
   localparam logic [BUF_AW:0] LVL_FULL = (BUF_AW + 1)'(DEPTH);
   localparam logic [BUF_AW:0] LVL_ONE  = (BUF_AW + 1)'(1);
   localparam logic [BUF_AW-1:0] PTR_ONE = BUF_AW'(1);

   logic [DBIT-1:0]   r_mem [DEPTH];
   logic [BUF_AW-1:0] r_wr_ptr;
   logic [BUF_AW-1:0] r_rd_ptr;
   logic [BUF_AW:0]   r_level;
   logic              w_do_push;
   logic              w_do_pop;

   assign o_full    = (r_level == LVL_FULL);
   assign o_empty   = (r_level == '0);
   assign o_level   = r_level;
   assign o_rdata   = r_mem[r_rd_ptr];
   assign w_do_push = i_push & ~o_full;
   assign w_do_pop  = i_pop & ~o_empty;

   // Pointers are exactly BUF_AW wide, so the increment wraps modulo depth.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
         case ({w_do_push, w_do_pop})
            2'b10:   r_level <= r_level + LVL_ONE;
            2'b01:   r_level <= r_level - LVL_ONE;
            default: r_level <= r_level;
         endcase
      end
   end

   // Storage is left unreset; the head is stale after reset but wr is low then.
   always_ff @(posedge clk) begin
      if (reset_n && w_do_push) r_mem[r_wr_ptr] <= i_wdata;
   end

endmodule

// File: rtl/uart_echo_ctrl.sv
// Pops words from an rx FIFO, transforms them per mode, buffers them and pushes them to a tx FIFO.
module uart_echo_ctrl
   import uart_echo_ctrl_pkg::*;
#(
   parameter int unsigned DBIT   = 8,
   parameter int unsigned BUF_AW = 2,
   parameter int unsigned CW     = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              en,
   input  logic [1:0]        mode,
   input  logic [DBIT-1:0]   r_data,
   input  logic              rx_empty,
   output logic              rd,
   input  logic              tx_full,
   output logic              wr,
   output logic [DBIT-1:0]   w_data,
   output logic [CW-1:0]     rx_count,
   output logic [BUF_AW:0]   buf_level
);

   logic            w_buf_full;
   logic            w_buf_empty;
   logic            w_push;
   logic [DBIT-1:0] w_xform;
   mode_e           w_mode;
   logic [CW-1:0]   r_rx_count;

   // Upper-casing only makes sense when a full ASCII byte fits in the word.
   function automatic logic [DBIT-1:0] f_xform(input mode_e m, input logic [DBIT-1:0] d);
      logic [8:0] w_ext;
      w_ext = 9'(d);
      case (m)
         MODE_UPPER: begin
            if (DBIT >= 8 && w_ext >= 9'(ASCII_LC_LO) && w_ext <= 9'(ASCII_LC_HI)) begin
               return DBIT'(w_ext - 9'(ASCII_CASE_OFS));
            end
            return d;
         end
         MODE_INV: return ~d;
         default:  return d;
      endcase
   endfunction

   assign w_mode   = mode_e'(mode);
   assign w_xform  = f_xform(w_mode, r_data);
   assign rd       = reset_n & en & ~rx_empty & ~w_buf_full;
   assign w_push   = rd & (w_mode != MODE_DISCARD);
   assign wr       = reset_n & ~w_buf_empty & ~tx_full;
   assign rx_count = r_rx_count;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_rx_count <= '0;
      end else if (rd) begin
         r_rx_count <= r_rx_count + CW'(1);
      end
   end

   echo_fifo #(
      .DBIT   (DBIT),
      .BUF_AW (BUF_AW)
   ) u_echo_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .i_push  (w_push),
      .i_pop   (wr),
      .i_wdata (w_xform),
      .o_rdata (w_data),
      .o_full  (w_buf_full),
      .o_empty (w_buf_empty),
      .o_level (buf_level)
   );

endmodule

// File: tb/tb_uart_echo_ctrl.sv
// Scoreboard bench for uart_echo_ctrl: rx FIFO source model, tx FIFO sink, expected-word queue.
module tb_uart_echo_ctrl;

   localparam int unsigned DBIT   = 8;
   localparam int unsigned BUF_AW = 2;
   localparam int unsigned CW     = 4;

   logic            clk;
   logic            reset_n;
   logic            en;
   logic [1:0]      mode;
   logic [DBIT-1:0] r_data;
   logic            rx_empty;
   logic            rd;
   logic            tx_full;
   logic            wr;
   logic [DBIT-1:0] w_data;
   logic [CW-1:0]   rx_count;
   logic [BUF_AW:0] buf_level;

   logic [7:0] rxq[$];
   logic [7:0] sbq[$];
   int n_checks = 0;
   int n_fail   = 0;
   int n_rd     = 0;
   int n_wr     = 0;
   int exp_count = 0;
   logic rd_s, wr_s;
   logic [7:0] wd_s;

   uart_echo_ctrl #(
      .DBIT   (DBIT),
      .BUF_AW (BUF_AW),
      .CW     (CW)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .en        (en),
      .mode      (mode),
      .r_data    (r_data),
      .rx_empty  (rx_empty),
      .rd        (rd),
      .tx_full   (tx_full),
      .wr        (wr),
      .w_data    (w_data),
      .rx_count  (rx_count),
      .buf_level (buf_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] model(input logic [1:0] m, input logic [7:0] d);
      case (m)
         2'b01:   return (d >= 8'h61 && d <= 8'h7A) ? d - 8'h20 : d;
         2'b10:   return ~d;
         default: return d;
      endcase
   endfunction

   task automatic enqueue(input logic [7:0] w);
      rxq.push_back(w);
      if (mode != 2'b11) sbq.push_back(model(mode, w));
   endtask

   // One cycle: present rx head, sample outputs, then apply pop/push effects at the edge.
   task automatic step();
      r_data   = (rxq.size() > 0) ? rxq[0] : 8'h00;
      rx_empty = (rxq.size() == 0);
      #1;
      rd_s = rd;
      wr_s = wr;
      wd_s = w_data;
      @(posedge clk);
      if (rd_s) begin
         void'(rxq.pop_front());
         n_rd++;
         exp_count++;
      end
      if (wr_s) begin
         n_wr++;
         if (sbq.size() == 0) check_eq("unexpected_wr", sbq.size(), 1);
         else check_eq("echo_data", wd_s, sbq.pop_front());
      end
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic drain(input int max_cycles);
      for (int i = 0; i < max_cycles && (rxq.size() > 0 || sbq.size() > 0); i++) step();
      check_eq("drain_left", rxq.size() + sbq.size(), 0);
   endtask

   // Reset with rx non-empty and tx not full so rd/wr gating by reset_n is exercised.
   task automatic do_reset();
      @(negedge clk);
      reset_n  = 1'b0;
      en       = 1'b1;
      tx_full  = 1'b0;
      rx_empty = 1'b0;
      r_data   = 8'hA5;
      #1;
      check_eq("rst_rd", rd, 0);
      check_eq("rst_wr", wr, 0);
      @(posedge clk);
      @(negedge clk);
      reset_n  = 1'b1;
      rx_empty = 1'b1;
      rxq.delete();
      sbq.delete();
      exp_count = 0;
      #1;
      check_eq("rst_level", buf_level, 0);
      check_eq("rst_count", rx_count, 0);
      check_eq("rst_wr_after", wr, 0);
   endtask

   initial begin
      reset_n  = 1'b0;
      en       = 1'b1;
      mode     = 2'b00;
      r_data   = '0;
      rx_empty = 1'b1;
      tx_full  = 1'b0;
      do_reset();

      // Single word pass-through with one-cycle latency
      mode = 2'b00;
      enqueue(8'h41);
      step();
      check_eq("lat_rd", rd_s, 1);
      check_eq("lat_wr0", wr_s, 0);
      step();
      check_eq("lat_wr1", wr_s, 1);
      check_eq("count_1", rx_count, 1);

      // Upper-case, then invert
      mode = 2'b01;
      enqueue(8'h61); enqueue(8'h5A); enqueue(8'h7B); enqueue(8'h7A); enqueue(8'h60);
      drain(40);
      mode = 2'b10;
      enqueue(8'h00); enqueue(8'h5A); enqueue(8'hC3);
      drain(40);
      check_eq("count_mix", rx_count, 32'(exp_count % 16));

      // Backpressure: buffer fills to depth, nothing lost afterwards
      mode = 2'b00;
      tx_full = 1'b1;
      n_rd = 0; n_wr = 0;
      for (int i = 0; i < 10; i++) enqueue(8'(8'h30 + i));
      run(12);
      check_eq("bp_rd", n_rd, 4);
      check_eq("bp_level", buf_level, 4);
      check_eq("bp_wr", n_wr, 0);
      tx_full = 1'b0;
      drain(60);
      check_eq("bp_rd_all", n_rd, 10);
      check_eq("bp_wr_all", n_wr, 10);

      // en low blocks pops while buffered words drain; mode change leaves them untouched
      mode = 2'b10;
      tx_full = 1'b1;
      enqueue(8'h0F); enqueue(8'hC3);
      run(4);
      check_eq("en_level", buf_level, 2);
      en = 1'b0;
      mode = 2'b00;
      enqueue(8'h61); enqueue(8'h7E);
      tx_full = 1'b0;
      n_rd = 0; n_wr = 0;
      run(6);
      check_eq("en_rd", n_rd, 0);
      check_eq("en_wr", n_wr, 2);
      check_eq("en_rxq", rxq.size(), 2);
      en = 1'b1;
      drain(20);

      // Discard mode
      do_reset();
      mode = 2'b11;
      n_rd = 0; n_wr = 0;
      for (int i = 0; i < 5; i++) enqueue(8'(8'h50 + i));
      drain(20);
      check_eq("disc_rd", n_rd, 5);
      check_eq("disc_wr", n_wr, 0);
      check_eq("disc_count", rx_count, 5);

      // Counter wrap with CW=4
      do_reset();
      for (int i = 0; i < 17; i++) enqueue(8'(i));
      drain(40);
      check_eq("wrap_count", rx_count, 1);

      // Reset mid-operation discards buffered words
      do_reset();
      mode = 2'b00;
      tx_full = 1'b1;
      enqueue(8'h11); enqueue(8'h22); enqueue(8'h33);
      run(5);
      check_eq("mid_level", buf_level, 3);
      do_reset();
      n_wr = 0;
      enqueue(8'h33);
      drain(10);
      check_eq("post_rst_wr", n_wr, 1);
      check_eq("post_rst_count", rx_count, 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_echo_ctrl.md
UART_ECHO_CTRL -- requirements
Module: uart_echo_ctrl

Interface
REQ-001 Parameter DBIT, default 8: data width in bits, range 5..9.
REQ-002 Parameter BUF_AW, default 2: buffer address width; buffer depth is 2**BUF_AW words, range 1..4.
REQ-003 Parameter CW, default 16: width of the received-word counter.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-006 en  input  1  1 = transfer enabled; 0 = stop popping the rx FIFO (buffer still drains).
REQ-007 mode  input  2  transform select: 00 pass, 01 ASCII upper-case, 10 bitwise invert, 11 discard.
REQ-008 r_data  input  DBIT  head word of the rx FIFO, valid whenever rx_empty=0.
REQ-009 rx_empty  input  1  rx FIFO empty flag.
REQ-010 rd  output  1  rx FIFO pop strobe.
REQ-011 tx_full  input  1  tx FIFO full flag.
REQ-012 wr  output  1  tx FIFO push strobe.
REQ-013 w_data  output  DBIT  word presented to the tx FIFO.
REQ-014 rx_count  output  CW  number of words popped since reset, modulo 2**CW.
REQ-015 buf_level  output  BUF_AW+1  current buffer occupancy, 0..2**BUF_AW.

Function
REQ-016 rd SHALL be combinational: rd = reset_n & en & ~rx_empty & ~buf_full.
REQ-017 On every clock edge with rd=1, the block SHALL capture r_data, apply the transform selected by mode in that cycle, and push the result into the internal buffer, except when mode=11.
REQ-018 Transform 01 SHALL map words 8'h61..8'h7A to word-32 and leave all other words unchanged; for DBIT<8 it SHALL act as pass.
REQ-019 Transform 10 SHALL output ~r_data over all DBIT bits.
REQ-020 Mode 11 SHALL pop and count the word without pushing it into the buffer.
REQ-021 wr SHALL be combinational: wr = reset_n & ~buf_empty & ~tx_full.
REQ-022 w_data SHALL always equal the buffer head word, with no combinational path from r_data.
REQ-023 The buffer SHALL pop on every edge with wr=1.
REQ-024 Latency: a word popped at edge N SHALL be presented with wr=1 in the cycle after edge N when tx_full=0.
REQ-025 Full buffer: rd=0 and no rx word is lost; popping resumes in the cycle after the first wr edge.
REQ-026 Simultaneous push and pop with 0 < level < depth: level unchanged, order preserved.
REQ-027 Simultaneous push and pop at level 0 is impossible, because wr requires a non-empty buffer.
REQ-028 Buffer read and write pointers SHALL wrap modulo depth; full and empty SHALL be derived from an extra pointer bit or from the level counter.
REQ-029 rx_count SHALL increment by 1 on every edge with rd=1 and wrap from 2**CW-1 to 0.
REQ-030 A change of mode SHALL affect only words popped after the change; words already buffered SHALL stay unmodified.
REQ-031 Deasserting en SHALL block further pops while buffered words continue to drain to tx.

Reset
REQ-032 While reset_n=0 at an edge, the block SHALL clear the buffer pointers and level, and set rx_count=0.
REQ-033 rd=0 and wr=0 SHALL hold throughout the reset cycle.
REQ-034 Reset mid-operation SHALL discard buffered words without emitting them.
REQ-035 After reset, w_data SHALL equal the stale buffer head, which is don't-care while wr=0.

Structure
REQ-036 A shared defines/package file SHALL hold the mode encodings (MODE_PASS, MODE_UPPER, MODE_INV, MODE_DISCARD) and the ASCII bounds 8'h61/8'h7A.
REQ-037 The buffer SHALL be a single sub-module echo_fifo, parametrised by DBIT and BUF_AW, with synchronous active-low reset and first-word-fall-through head output.
REQ-038 The transform logic SHALL be a function or combinational block inside uart_echo_ctrl.

Verification
REQ-039 Scenario: mode=00, feed 8'h41 with tx_full=0 -> rd for one cycle; in the next cycle wr=1 with w_data=8'h41; rx_count=1.
REQ-040 Scenario: mode=01, feed "a", "Z", "{" -> tx receives 8'h41, 8'h5A, 8'h7B in order.
REQ-041 Scenario: tx_full=1, 10 rx words queued, BUF_AW=2 -> exactly 4 rd pulses and buf_level=4; after release of tx_full all 10 words arrive in order with no loss.
REQ-042 Scenario: mode=11, 5 words -> 5 rd pulses, no wr pulses, rx_count=5.
REQ-043 Scenario: CW=4, 17 words -> rx_count=1 (wrap).
REQ-044 Scenario: reset_n=0 asserted with buf_level=3 -> next cycle buf_level=0, wr=0, rx_count=0; a subsequent word echoes normally.
